// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
// Output bundles are named so the FSM reads as a table of pipeline actions.
package pipe_ctrl_pkg;

  localparam int REG_W = 3;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    FLUSH    = 2'd2,
    HALT     = 2'd3
  } pc_state_t;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
  } ctrl_out_t;

  localparam ctrl_out_t CTRL_RUN    = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0,
                                        id_ex_en: 1'b1, id_ex_flush: 1'b0};
  localparam ctrl_out_t CTRL_RESET  = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b1,
                                        id_ex_en: 1'b0, id_ex_flush: 1'b1};
  localparam ctrl_out_t CTRL_FREEZE = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0,
                                        id_ex_en: 1'b0, id_ex_flush: 1'b0};
  localparam ctrl_out_t CTRL_HALT   = '{pc_en: 1'b0, if_id_en: 1'b1, if_id_flush: 1'b1,
                                        id_ex_en: 1'b1, id_ex_flush: 1'b1};
  localparam ctrl_out_t CTRL_BRANCH = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b1,
                                        id_ex_en: 1'b1, id_ex_flush: 1'b1};
  localparam ctrl_out_t CTRL_STALL  = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0,
                                        id_ex_en: 1'b1, id_ex_flush: 1'b1};
  localparam ctrl_out_t CTRL_FLUSH  = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b1,
                                        id_ex_en: 1'b1, id_ex_flush: 1'b0};

  // Width of a down-counter that must hold n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: ID-stage sources against the destination of a load in EX.
// Register 0 is compared like any other register.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_reg1,
  input  logic [REG_W-1:0] id_reg2,
  input  logic             id_uses1,
  input  logic             id_uses2,
  input  logic             ex_read_mem,
  input  logic             ex_write_reg,
  input  logic [REG_W-1:0] ex_dest,
  output logic             hazard
);

  logic match1;
  logic match2;

  assign match1 = id_uses1 && (id_reg1 == ex_dest);
  assign match2 = id_uses2 && (id_reg2 == ex_dest);
  assign hazard = ex_read_mem && ex_write_reg && (match1 || match2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: load-use stalls, branch squash, memory-wait freeze and HALT parking.
// Outputs are combinational from the current state and this cycle's inputs.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int LOAD_STALLS  = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_reg1,
  input  logic [REG_W-1:0] id_reg2,
  input  logic             id_uses1,
  input  logic             id_uses2,
  input  logic             ex_read_mem,
  input  logic             ex_write_reg,
  input  logic [REG_W-1:0] ex_dest,
  input  logic             ex_branch_taken,
  input  logic             ex_halt,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int FC_W = cnt_w(FLUSH_CYCLES);
  localparam int LC_W = cnt_w(LOAD_STALLS);

  pc_state_t        state_q, state_d;
  logic [FC_W-1:0]  fcnt_q, fcnt_d;
  logic [LC_W-1:0]  lcnt_q, lcnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  ctrl_out_t        ctrl;
  logic             halted_c;
  logic             hazard;

  hazard_detect u_hazard_detect (
    .id_reg1      (id_reg1),
    .id_reg2      (id_reg2),
    .id_uses1     (id_uses1),
    .id_uses2     (id_uses2),
    .ex_read_mem  (ex_read_mem),
    .ex_write_reg (ex_write_reg),
    .ex_dest      (ex_dest),
    .hazard       (hazard)
  );

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    fcnt_d   = fcnt_q;
    lcnt_d   = lcnt_q;
    ctrl     = CTRL_RUN;
    halted_c = 1'b0;

    if (reset) begin
      ctrl = CTRL_RESET;
    end else begin
      unique case (state_q)
        RUN: begin
          if (ex_halt) begin
            ctrl    = CTRL_HALT;
            state_d = HALT;
          end else if (ex_branch_taken) begin
            ctrl = CTRL_BRANCH;
            if (FLUSH_CYCLES > 1) begin
              state_d = FLUSH;
              fcnt_d  = FC_W'(FLUSH_CYCLES - 1);
            end
          end else if (mem_busy) begin
            ctrl = CTRL_FREEZE;
          end else if (hazard) begin
            ctrl = CTRL_STALL;
            if (LOAD_STALLS > 1) begin
              state_d = LU_STALL;
              lcnt_d  = LC_W'(LOAD_STALLS - 1);
            end
          end
        end
        // The load is still waiting in EX, so a memory wait simply holds the bubble count.
        LU_STALL: begin
          if (mem_busy) begin
            ctrl = CTRL_FREEZE;
          end else begin
            ctrl   = CTRL_STALL;
            lcnt_d = lcnt_q - 1'b1;
            if (lcnt_q == LC_W'(1)) state_d = RUN;
          end
        end
        FLUSH: begin
          if (mem_busy) begin
            ctrl = CTRL_FREEZE;
          end else begin
            ctrl   = CTRL_FLUSH;
            fcnt_d = fcnt_q - 1'b1;
            if (fcnt_q == FC_W'(1)) state_d = RUN;
          end
        end
        HALT: begin
          ctrl     = CTRL_FREEZE;
          halted_c = 1'b1;
        end
        default: state_d = RUN;
      endcase
    end

    stall_cnt_d = stall_cnt_q;
    if (!ctrl.pc_en && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      fcnt_q      <= '0;
      lcnt_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      lcnt_q      <= lcnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign pc_en       = ctrl.pc_en;
  assign if_id_en    = ctrl.if_id_en;
  assign if_id_flush = ctrl.if_id_flush;
  assign id_ex_en    = ctrl.id_ex_en;
  assign id_ex_flush = ctrl.id_ex_flush;
  assign halted      = halted_c;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: a default instance driven from a vector table and a
// CNT_W=4 / LOAD_STALLS=2 / FLUSH_CYCLES=1 instance driven by hand-written sequences.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic       reset;
    logic [2:0] r1;
    logic [2:0] r2;
    logic       u1;
    logic       u2;
    logic       rm;
    logic       wr;
    logic [2:0] dest;
    logic       br;
    logic       halt;
    logic       busy;
  } in_t;

  // ctl bit order: {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush}
  typedef struct packed {
    logic [4:0]  ctl;
    logic        halted;
    logic [15:0] st;
  } exp_t;

  typedef struct {
    string name;
    in_t   in;
    exp_t  e;
  } vec_t;

  typedef struct {
    bit    dut_b;
    string name;
    exp_t  e;
  } sb_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  in_t a_in, b_in;
  int  n_vec = 0;
  int  n_err = 0;
  sb_t sb[$];
  vec_t tbl_a[$];

  logic        a_pc, a_ife, a_iff, a_ide, a_idf, a_halted;
  logic [15:0] a_st;
  logic        b_pc, b_ife, b_iff, b_ide, b_idf, b_halted;
  logic [3:0]  b_st;

  pipe_hazard_ctrl dut_a (
    .clk(clk), .reset(a_in.reset),
    .id_reg1(a_in.r1), .id_reg2(a_in.r2), .id_uses1(a_in.u1), .id_uses2(a_in.u2),
    .ex_read_mem(a_in.rm), .ex_write_reg(a_in.wr), .ex_dest(a_in.dest),
    .ex_branch_taken(a_in.br), .ex_halt(a_in.halt), .mem_busy(a_in.busy),
    .pc_en(a_pc), .if_id_en(a_ife), .if_id_flush(a_iff), .id_ex_en(a_ide),
    .id_ex_flush(a_idf), .halted(a_halted), .stall_cnt(a_st)
  );

  pipe_hazard_ctrl #(.FLUSH_CYCLES(1), .LOAD_STALLS(2), .CNT_W(4)) dut_b (
    .clk(clk), .reset(b_in.reset),
    .id_reg1(b_in.r1), .id_reg2(b_in.r2), .id_uses1(b_in.u1), .id_uses2(b_in.u2),
    .ex_read_mem(b_in.rm), .ex_write_reg(b_in.wr), .ex_dest(b_in.dest),
    .ex_branch_taken(b_in.br), .ex_halt(b_in.halt), .mem_busy(b_in.busy),
    .pc_en(b_pc), .if_id_en(b_ife), .if_id_flush(b_iff), .id_ex_en(b_ide),
    .id_ex_flush(b_idf), .halted(b_halted), .stall_cnt(b_st)
  );

  function automatic in_t f_idle();
    return '0;
  endfunction

  function automatic in_t f_rst();
    in_t t = '0;
    t.reset = 1'b1;
    return t;
  endfunction

  function automatic in_t f_ld(input logic [2:0] dest, input logic [2:0] r1, input logic u1,
                               input logic [2:0] r2, input logic u2, input logic wr);
    in_t t = '0;
    t.rm = 1'b1; t.wr = wr; t.dest = dest;
    t.r1 = r1; t.u1 = u1; t.r2 = r2; t.u2 = u2;
    return t;
  endfunction

  function automatic in_t f_ctl(input logic br, input logic halt, input logic busy);
    in_t t = '0;
    t.br = br; t.halt = halt; t.busy = busy;
    return t;
  endfunction

  function automatic vec_t mkv(input string nm, input in_t i, input logic [4:0] ctl,
                               input logic h, input int st);
    vec_t v;
    v.name     = nm;
    v.in       = i;
    v.e.ctl    = ctl;
    v.e.halted = h;
    v.e.st     = 16'(st);
    return v;
  endfunction

  task automatic compare();
    sb_t  s;
    exp_t act;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard: nothing expected when output was sampled");
      return;
    end
    s = sb.pop_front();
    if (s.dut_b) act = '{ctl: {b_pc, b_ife, b_iff, b_ide, b_idf}, halted: b_halted, st: {12'd0, b_st}};
    else         act = '{ctl: {a_pc, a_ife, a_iff, a_ide, a_idf}, halted: a_halted, st: a_st};
    n_vec++;
    if (act !== s.e) begin
      n_err++;
      $display("FAIL %s (dut_%s): got ctl=%b halted=%b stall_cnt=%0d, want ctl=%b halted=%b stall_cnt=%0d",
               s.name, s.dut_b ? "b" : "a", act.ctl, act.halted, act.st,
               s.e.ctl, s.e.halted, s.e.st);
    end
  endtask

  // Drive one cycle's inputs just after the edge, check the settled outputs mid-cycle.
  task automatic step(input bit dut_b, input vec_t v);
    sb_t s;
    @(posedge clk);
    #1;
    if (dut_b) b_in = v.in;
    else       a_in = v.in;
    s.dut_b = dut_b;
    s.name  = v.name;
    s.e     = v.e;
    sb.push_back(s);
    @(negedge clk);
    compare();
  endtask

  initial begin
    in_t t;

    tbl_a.push_back(mkv("rst",        f_rst(),                  5'b00101, 1'b0, 0));
    tbl_a.push_back(mkv("idle",       f_idle(),                 5'b11010, 1'b0, 0));
    tbl_a.push_back(mkv("lu_r1",      f_ld(3, 3, 1, 0, 0, 1),   5'b00011, 1'b0, 0));
    tbl_a.push_back(mkv("after_lu",   f_idle(),                 5'b11010, 1'b0, 1));
    tbl_a.push_back(mkv("no_use",     f_ld(3, 3, 0, 0, 0, 1),   5'b11010, 1'b0, 1));
    tbl_a.push_back(mkv("no_wr",      f_ld(3, 3, 1, 0, 0, 0),   5'b11010, 1'b0, 1));
    tbl_a.push_back(mkv("lu_r2",      f_ld(5, 1, 1, 5, 1, 1),   5'b00011, 1'b0, 1));
    tbl_a.push_back(mkv("lu_r0",      f_ld(0, 0, 1, 0, 0, 1),   5'b00011, 1'b0, 2));
    t = f_ld(3, 3, 1, 0, 0, 1); t.rm = 1'b0;
    tbl_a.push_back(mkv("not_load",   t,                        5'b11010, 1'b0, 3));
    tbl_a.push_back(mkv("mismatch",   f_ld(6, 6, 0, 5, 1, 1),   5'b11010, 1'b0, 3));
    tbl_a.push_back(mkv("branch",     f_ctl(1, 0, 0),           5'b11111, 1'b0, 3));
    tbl_a.push_back(mkv("flush1",     f_idle(),                 5'b11110, 1'b0, 3));
    tbl_a.push_back(mkv("br_done",    f_idle(),                 5'b11010, 1'b0, 3));
    t = f_ld(2, 2, 1, 0, 0, 1); t.br = 1'b1; t.busy = 1'b1;
    tbl_a.push_back(mkv("br_hz_busy", t,                        5'b11111, 1'b0, 3));
    tbl_a.push_back(mkv("fl_busy1",   f_ctl(0, 0, 1),           5'b00000, 1'b0, 3));
    tbl_a.push_back(mkv("fl_busy2",   f_ctl(0, 0, 1),           5'b00000, 1'b0, 4));
    tbl_a.push_back(mkv("fl_resume",  f_idle(),                 5'b11110, 1'b0, 5));
    tbl_a.push_back(mkv("run_again",  f_idle(),                 5'b11010, 1'b0, 5));
    t = f_ld(2, 2, 1, 0, 0, 1); t.busy = 1'b1;
    tbl_a.push_back(mkv("busy_hz",    t,                        5'b00000, 1'b0, 5));
    tbl_a.push_back(mkv("after_busy", f_idle(),                 5'b11010, 1'b0, 6));
    tbl_a.push_back(mkv("halt_br",    f_ctl(1, 1, 0),           5'b01111, 1'b0, 6));
    tbl_a.push_back(mkv("halted1",    f_idle(),                 5'b00000, 1'b1, 7));
    tbl_a.push_back(mkv("halted2",    f_ctl(1, 0, 1),           5'b00000, 1'b1, 8));
    tbl_a.push_back(mkv("halted3",    f_idle(),                 5'b00000, 1'b1, 9));
    tbl_a.push_back(mkv("halt_rst",   f_rst(),                  5'b00101, 1'b0, 10));
    tbl_a.push_back(mkv("post_rst",   f_idle(),                 5'b11010, 1'b0, 0));
    tbl_a.push_back(mkv("lu_both",    f_ld(7, 7, 1, 7, 1, 1),   5'b00011, 1'b0, 0));
    tbl_a.push_back(mkv("tail",       f_idle(),                 5'b11010, 1'b0, 1));

    a_in = f_rst();
    b_in = f_rst();
    repeat (2) @(posedge clk);

    for (int i = 0; i < tbl_a.size(); i++) step(1'b0, tbl_a[i]);
    a_in = f_idle();

    // Two-bubble load-use, memory wait inside the stall, single-cycle branch flush.
    step(1'b1, mkv("b_lu",        f_ld(4, 4, 1, 0, 0, 1), 5'b00011, 1'b0, 0));
    step(1'b1, mkv("b_lu2",       f_idle(),               5'b00011, 1'b0, 1));
    step(1'b1, mkv("b_lu_done",   f_idle(),               5'b11010, 1'b0, 2));
    step(1'b1, mkv("b_lu_again",  f_ld(4, 4, 1, 0, 0, 1), 5'b00011, 1'b0, 2));
    step(1'b1, mkv("b_lu_busy",   f_ctl(0, 0, 1),         5'b00000, 1'b0, 3));
    step(1'b1, mkv("b_lu_resume", f_idle(),               5'b00011, 1'b0, 4));
    step(1'b1, mkv("b_lu_exit",   f_idle(),               5'b11010, 1'b0, 5));
    step(1'b1, mkv("b_branch",    f_ctl(1, 0, 0),         5'b11111, 1'b0, 5));
    step(1'b1, mkv("b_br_done",   f_idle(),               5'b11010, 1'b0, 5));

    // Reset arriving in the middle of a multi-cycle load-use stall.
    step(1'b1, mkv("b_lu_pre_rst", f_ld(4, 4, 1, 0, 0, 1), 5'b00011, 1'b0, 5));
    step(1'b1, mkv("b_mid_rst",    f_rst(),                5'b00101, 1'b0, 6));
    step(1'b1, mkv("b_run_after",  f_idle(),               5'b11010, 1'b0, 0));

    // Long memory wait drives the 4-bit counter into saturation.
    for (int i = 0; i < 20; i++)
      step(1'b1, mkv($sformatf("b_sat%0d", i), f_ctl(0, 0, 1), 5'b00000, 1'b0, (i > 15) ? 15 : i));
    step(1'b1, mkv("b_sat_hold", f_idle(), 5'b11010, 1'b0, 15));

    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
